// File: rtl/alarm_set_arbiter_if.sv
// Alarm-set control bundle between the arbiter and the alarm comparator.
// The arbiter drives it through the out (or master) view; the comparator reads it through the slave view.
interface posix_time_ctrl_if;
    logic [31:0] usr_posix_time;
    logic        usr_posix_time_en;
    logic        usr_unset_alarm;

    modport master (
        output usr_posix_time,
        output usr_posix_time_en,
        output usr_unset_alarm
    );

    modport out (
        output usr_posix_time,
        output usr_posix_time_en,
        output usr_unset_alarm
    );

    modport slave (
        input usr_posix_time,
        input usr_posix_time_en,
        input usr_unset_alarm
    );
endinterface

// File: rtl/alarm_set_arbiter.sv
// Two-requester arbiter for the alarm-set interface, with a quiet gap after each command.
// Define ALARM_SET_ARB_RR_EN for round-robin tie breaking; the default is fixed priority, requester 0 first.
//   state | meaning
//   IDLE  | sampling req_i; a grant drives the pulse and ack on the same edge
//   ISSUE | the one cycle where the pulse and ack are visible
//   GAP   | GAP_CYCLES quiet cycles; requests are ignored
module alarm_set_arbiter #(
    parameter int GAP_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       req_i,
    input  logic [1:0]       unset_i,
    input  logic [31:0]      time0_i,
    input  logic [31:0]      time1_i,
    output logic [1:0]       ack_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] cnt0_o,
    output logic [CNT_W-1:0] cnt1_o,
    posix_time_ctrl_if.out   alarm_set_time_if
);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    state_t           state;
    logic [GAP_W-1:0] gap_cnt;
    logic             winner;
    logic             win_unset;
    logic [31:0]      win_time;

`ifdef ALARM_SET_ARB_RR_EN
    logic last_grant;

    // Only a tie looks at the last grant; a lone request always wins.
    always_comb begin
        winner = ~req_i[0];
        if (req_i == 2'b11) winner = ~last_grant;
    end
`else
    always_comb winner = ~req_i[0];
`endif

    assign win_unset = winner ? unset_i[1] : unset_i[0];
    assign win_time  = winner ? time1_i : time0_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state                               <= IDLE;
            gap_cnt                             <= '0;
            ack_o                               <= 2'b00;
            busy_o                              <= 1'b0;
            cnt0_o                              <= '0;
            cnt1_o                              <= '0;
            alarm_set_time_if.usr_posix_time    <= '0;
            alarm_set_time_if.usr_posix_time_en <= 1'b0;
            alarm_set_time_if.usr_unset_alarm   <= 1'b0;
`ifdef ALARM_SET_ARB_RR_EN
            last_grant                          <= 1'b1;
`endif
        end else begin
            ack_o                               <= 2'b00;
            alarm_set_time_if.usr_posix_time_en <= 1'b0;
            alarm_set_time_if.usr_unset_alarm   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i != 2'b00) begin
                        state  <= ISSUE;
                        busy_o <= 1'b1;
                        ack_o  <= winner ? 2'b10 : 2'b01;
`ifdef ALARM_SET_ARB_RR_EN
                        last_grant <= winner;
`endif
                        // An unset leaves the last programmed time on the bus.
                        if (win_unset) begin
                            alarm_set_time_if.usr_unset_alarm <= 1'b1;
                        end else begin
                            alarm_set_time_if.usr_posix_time_en <= 1'b1;
                            alarm_set_time_if.usr_posix_time    <= win_time;
                        end
                        if (!winner) begin
                            if (cnt0_o != '1) cnt0_o <= cnt0_o + 1'b1;
                        end else begin
                            if (cnt1_o != '1) cnt1_o <= cnt1_o + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (GAP_CYCLES > 0) begin
                        state   <= GAP;
                        gap_cnt <= GAP_LOAD;
                    end else begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/alarm_set_arbiter.md
Name: alarm_set_arbiter

Overview:
Shares the alarm clock's single alarm-set control interface (posix_time_ctrl_if, out side) between two requesters: the host register bank (requester 0) and the front-panel button UI (requester 1).
- Accepts set/unset commands over a req/ack handshake.
- Grants one command at a time.
- Drives the interface with single-cycle enable/unset pulses.
- Enforces a programmable quiet gap between commands so the downstream alarm comparator can absorb each update.

Parameters:
GAP_CYCLES, 4, idle cycles forced after each issued command before the next grant (0 allowed).
CNT_W, 16, width of the per-requester accepted-command counters.

Ports:
clk_i  in  1  system clock.
rst_i  in  1  reset, asynchronous, active-low.
req_i  in  2  per-requester command request; bit n belongs to requester n; held high until ack.
unset_i  in  2  per-requester command type, qualified by req_i: 1 = unset alarm, 0 = set alarm.
time0_i  in  32  requester 0 POSIX alarm time, qualified by req_i[0] and unset_i[0]=0.
time1_i  in  32  requester 1 POSIX alarm time, qualified by req_i[1] and unset_i[1]=0.
ack_o  out  2  one-cycle acknowledge to the granted requester.
busy_o  out  1  high whenever the FSM is not in IDLE.
cnt0_o  out  CNT_W  commands accepted from requester 0; saturating.
cnt1_o  out  CNT_W  commands accepted from requester 1; saturating.
alarm_set_time_if  posix_time_ctrl_if.out  -  fields: usr_posix_time[31:0], usr_posix_time_en, usr_unset_alarm.

Behaviour:
- All outputs are registered.
- Reset values: usr_posix_time=0, usr_posix_time_en=0, usr_unset_alarm=0, ack_o=0, busy_o=0, cnt0_o=0, cnt1_o=0, FSM=IDLE, gap counter=0.
- Reset assertion mid-operation aborts any command immediately; no pulse completes.

FSM states: IDLE, ISSUE, GAP.
- IDLE: on a clock edge with req_i != 0, choose the winner, latch its unset bit and time, go to ISSUE.
- ISSUE (exactly one cycle):
  - Set command: usr_posix_time=latched time, usr_posix_time_en=1, usr_unset_alarm=0.
  - Unset command: usr_unset_alarm=1, usr_posix_time_en=0, usr_posix_time keeps its previous value.
  - ack_o[winner]=1.
  - Winner's counter increments; it saturates at all-ones and does not wrap.
  - Next state: GAP if GAP_CYCLES>0, else IDLE.
- GAP: stays exactly GAP_CYCLES cycles with pulses low, then returns to IDLE. Requests are not sampled during GAP.

Timing and handshake:
- Latency: req sampled at edge N -> pulse and ack both visible in cycle N+1.
- Earliest next grant is at edge N+2+GAP_CYCLES.
- usr_posix_time_en and usr_unset_alarm are never high together and never high for two consecutive cycles.
- Requester must hold req, unset and time stable until ack. Requester drops req on the cycle after ack; a req still high after ack is treated as a new command.
- req dropped before grant: nothing is issued, no error.
- Arbitration (default, without macro): fixed priority; requester 0 wins when both req_i bits are sampled high. The loser stays pending and is served on the next IDLE sample.

Optional Feature:
ALARM_SET_ARB_RR_EN
- Defined: round-robin arbitration. A one-bit last-grant register (reset = 1, so requester 0 wins the first tie) gives priority to the requester not served last. Only ties consult it; a lone request is always granted.
- Undefined: fixed priority, requester 0 over requester 1; last-grant register not built.

Test Plan:
1. Reset release; req_i=01, unset_i=00, time0_i=0x5F5E1000 -> cycle N+1: usr_posix_time=0x5F5E1000, en=1 for one cycle, ack_o=01, cnt0_o=1, busy_o high 1+4 cycles.
2. req_i=10, unset_i=10 after test 1 -> usr_unset_alarm one-cycle pulse, en=0, usr_posix_time stays 0x5F5E1000, ack_o=10, cnt1_o=1.
3. req_i=11 held, time0=0x100, time1=0x200, fixed priority -> 0x100 issued first, then 0x200 issued exactly 6 cycles after the first pulse (1 + GAP 4 + 1); with ALARM_SET_ARB_RR_EN, repeated ties alternate 0,1,0,1.
4. GAP_CYCLES=0, continuous req_i=01 -> en pulses every 2nd cycle, never back-to-back.
5. Assert rst_i low in the ISSUE cycle -> all outputs 0 asynchronously; after release FSM is IDLE and the pending req is re-served.
6. CNT_W=2, issue 5 commands from requester 0 -> cnt0_o reads 3 (saturated), no wrap.
